ifetch_queue: RTL
=================

# ifetch_queue

Instruction prefetch queue between instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered with their PC+4 in a small FIFO and presented to the decode stage, which pops them unless it is stalled. Jump and taken-branch redirects flush the queue and restart fetch at the new target.

## Interface
- `DEPTH`, default 4: queue entries, a power of two ≥ 2.
- `RESET_PC`, default 32'h0000_0000: fetch address after reset. Word-aligned.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: read request. Held until `imem_ack`.
- `imem_addr` out 32: word address. Stable while `imem_req` is high.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle. Ignored when `imem_req` is 0.
- `imem_rdata` in 32: instruction word.
- `redirect` in 1: flush the queue and restart fetch.
- `redirect_pc` in 32: new fetch address. Word-aligned.
- `stall` in 1: decode cannot accept this cycle.
- `out_valid` out 1: head entry is valid.
- `out_instr` out 32: head instruction. 32'h0 (NOP) when `out_valid` is 0.
- `out_pc4` out 32: head PC+4. 0 when `out_valid` is 0.
- `count` out log2(DEPTH)+1: current occupancy.

## Operation
- State:
  - `fetch_pc`
  - FIFO storage with read pointer, write pointer and `count`
  - `pend`: request outstanding
  - `drop`: discard the next ack
- Issue:
  - `imem_req` rises on a cycle when `pend`=0 and either `count` < DEPTH or `drop`=1.
  - `imem_addr` = `fetch_pc`.
  - Once raised, `imem_req` stays high with `imem_addr` unchanged until ack, regardless of `count`, `stall` or `redirect`. Only reset clears it.
- Ack with `drop`=0 and `redirect`=0:
  - Push {`imem_rdata`, `fetch_pc`+4}.
  - `fetch_pc` += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Ack with `drop`=1: data discarded, `drop` cleared, no push.
- Pop: when `out_valid` && !`stall`, the read pointer advances.
- Simultaneous push and pop: `count` is unchanged. A push into a full queue cannot occur, by the issue rule.
- Redirect (wins over push, pop and stall):
  - Queue emptied, `count`=0.
  - `fetch_pc` = `redirect_pc`.
  - If a request is outstanding and not acked this cycle, set `drop`.
  - If acked in the same cycle, the data is discarded and `drop` stays 0.
  - A redirect while `drop`=1 keeps `drop`=1 and overwrites `fetch_pc`.
- `out_valid` = (`count` != 0). `out_instr` and `out_pc4` come from the head entry, otherwise 0.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc4`=0, `count`=0.
  - `pend`=0, `drop`=0, pointers=0.
- First request is issued the first cycle after `rst_n` deasserts.
- Reset mid-transaction: `imem_req` drops asynchronously. The memory abandons the transfer.
- Ack in cycle n produces `out_valid` in cycle n+1 (queue empty, no bypass).
- With zero-wait memory (ack the same cycle as req): one instruction per cycle sustained.
  - On an ack, `pend` clears at the edge and the next request is eligible the following cycle.
- First request after a redirect:
  - Cycle r+1 if nothing was outstanding.
  - Otherwise the cycle after the dropped ack.
- Flushed data never appears on the outputs.

## Configuration
- `IFQ_BYPASS_EN` defined: when `count`=0, ack with `drop`=0, and `redirect`=0:
  - Outputs show `imem_rdata` and `fetch_pc`+4 combinationally, with `out_valid`=1 in the ack cycle.
  - If `stall`=0, the word is consumed and not written.
  - If `stall`=1, it is pushed as normal.
- `IFQ_BYPASS_EN` undefined: minimum latency ack→`out_valid` is one cycle, and all outputs are register-driven.

## Test plan
- Reset, then ack every cycle, `stall`=0, memory returns addr^32'hA5A5_0000:
  - `out_pc4` sequence 4, 8, 12, … one per cycle from the second cycle.
  - `count` ≤ 1.
- `stall`=1 held for 10 cycles with ack every cycle:
  - `count` saturates at 4 and `imem_req` stays 0 afterward.
  - Releasing the stall drains 4 entries in order (`out_pc4` 4, 8, 12, 16).
- Request outstanding at 32'h40 with ack delayed 3 cycles, `redirect`=1 to 32'h200 in the first wait cycle:
  - `imem_addr` stays 32'h40 until ack.
  - The ack'd word never appears.
  - Next request is 32'h200, and the first `out_pc4` is 32'h204.
- `redirect` to 32'h1000 coinciding with an ack and a pop, 3 entries queued:
  - `count`=0 next cycle, `out_valid`=0, `out_instr`=0.
  - Next `imem_addr`=32'h1000.
- `redirect_pc`=32'hFFFF_FFF8 with zero-wait memory:
  - `out_pc4` sequence FFFF_FFFC, 0000_0000, 0000_0004.
- With `IFQ_BYPASS_EN`, empty queue, ack with `stall`=0: `out_valid`=1 in the ack cycle and `count` stays 0. With `stall`=1 on the same ack, `count`=1 the next cycle.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues word reads over req/ack and
// buffers {instr, pc+4} for decode. Define IFQ_BYPASS_EN to forward an ack into an empty queue.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  input  logic                    stall,
  output logic                    out_valid,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc4,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          pend;
  logic          drop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];

  logic          full;
  logic          accept;
  logic          fresh;
  logic          bypass_hit;
  logic          push;
  logic          pop;
  logic [31:0]   next_pc;

  // A raised request is held by pend; the address is latched so a redirect cannot disturb it.
  assign full      = (count == CW'(DEPTH));
  assign imem_req  = pend | (rst_n & (~full | drop));
  assign imem_addr = pend ? req_addr : fetch_pc;
  assign accept    = imem_req & imem_ack;
  assign fresh     = accept & ~drop & ~redirect;
  assign next_pc   = imem_addr + 32'd4;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = fresh & (count == CW'(0));
`else
  assign bypass_hit = 1'b0;
`endif

  assign push = fresh & ~(bypass_hit & ~stall);
  assign pop  = (count != CW'(0)) & ~stall;

  // Head of queue, or the forwarded ack word, onto the decode outputs.
  always_comb begin
    out_valid = 1'b0;
    out_instr = 32'h0;
    out_pc4   = 32'h0;
    if (count != CW'(0)) begin
      out_valid = 1'b1;
      out_instr = instr_mem[rd_ptr];
      out_pc4   = pc4_mem[rd_ptr];
    end else if (bypass_hit) begin
      out_valid = 1'b1;
      out_instr = imem_rdata;
      out_pc4   = next_pc;
    end else begin
      out_valid = 1'b0;
    end
  end

  // Fetch PC, request handshake, drop flag and queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      pend     <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pend <= imem_req & ~imem_ack;
      if (!pend) begin
        req_addr <= fetch_pc;
      end
      if (accept) begin
        drop <= 1'b0;
      end else if (redirect && imem_req) begin
        drop <= 1'b1;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (fresh) begin
          fetch_pc <= next_pc;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  // Queue storage; entries are only read while count covers them, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc4_mem[wr_ptr]   <= next_pc;
    end
  end

endmodule
